// File: rtl/pifo_sorted.sv
// pifo_sorted: push-in-first-out priority queue kept as a sorted register array; entry[0] is the head.
// Optional macro PIFO_DROP_TAIL_EN: a push into a full queue with a strictly better rank evicts the tail.
module pifo_sorted #(
   parameter int NUM_ELEMENTS   = 16,
   parameter int PRIORITY_WIDTH = 8,
   parameter int DATA_WIDTH     = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 i__enqueue,
   input  logic [PRIORITY_WIDTH-1:0]            i__enqueue_priority,
   input  logic [DATA_WIDTH-1:0]                i__enqueue_data,
   input  logic                                 i__dequeue,
   output logic [PRIORITY_WIDTH-1:0]            o__dequeue_priority,
   output logic [DATA_WIDTH-1:0]                o__dequeue_data,
   output logic                                 o__pifo_full,
   output logic                                 o__pifo_empty,
   output logic [$clog2(NUM_ELEMENTS+1)-1:0]    o__occupancy,
   output logic                                 o__overflow,
   output logic                                 o__underflow,
   output logic                                 o__drop_valid,
   output logic [DATA_WIDTH-1:0]                o__drop_data
);

   localparam int OCC_WIDTH = $clog2(NUM_ELEMENTS + 1);

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_PUSH_POP
   } op_t;

   logic [NUM_ELEMENTS-1:0]   entry_valid;
   logic [PRIORITY_WIDTH-1:0] entry_priority [NUM_ELEMENTS];
   logic [DATA_WIDTH-1:0]     entry_data     [NUM_ELEMENTS];

   logic [NUM_ELEMENTS-1:0]   valid_next;
   logic [PRIORITY_WIDTH-1:0] priority_next  [NUM_ELEMENTS];
   logic [DATA_WIDTH-1:0]     data_next      [NUM_ELEMENTS];

   logic [NUM_ELEMENTS:0]     le;
   logic [NUM_ELEMENTS-1:0]   ins_at;
   logic [NUM_ELEMENTS-1:0]   ins_pp;

   op_t                       op;
   logic                      is_empty;
   logic                      is_full;
   logic                      overflow_next;
   logic                      underflow_next;
   logic [OCC_WIDTH-1:0]      occ_next;
`ifdef PIFO_DROP_TAIL_EN
   logic                      evict;
`endif

   // le is a prefix mask of entries ranked at or below the new rank, so insert slots fall out of its edge
   always_comb begin
      le = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         le[i] = entry_valid[i] && (entry_priority[i] <= i__enqueue_priority);
      end
      ins_at = ~le[NUM_ELEMENTS-1:0] & {le[NUM_ELEMENTS-2:0], 1'b1};
      ins_pp = ~le[NUM_ELEMENTS:1] & (le[NUM_ELEMENTS-1:0] | {{(NUM_ELEMENTS-1){1'b0}}, 1'b1});
   end

   always_comb begin
      is_empty       = !entry_valid[0];
      is_full        = entry_valid[NUM_ELEMENTS-1];
      op             = OP_NONE;
      overflow_next  = 1'b0;
      underflow_next = i__dequeue && is_empty;
      occ_next       = o__occupancy;
`ifdef PIFO_DROP_TAIL_EN
      evict          = 1'b0;
`endif
      if (i__enqueue) begin
         if (i__dequeue && !is_empty) begin
            op = OP_PUSH_POP;
         end else if (!is_full) begin
            op       = OP_PUSH;
            occ_next = o__occupancy + OCC_WIDTH'(1);
`ifdef PIFO_DROP_TAIL_EN
         end else if (i__enqueue_priority < entry_priority[NUM_ELEMENTS-1]) begin
            op    = OP_PUSH;
            evict = 1'b1;
`endif
         end else begin
            overflow_next = 1'b1;
         end
      end else if (i__dequeue && !is_empty) begin
         op       = OP_POP;
         occ_next = o__occupancy - OCC_WIDTH'(1);
      end
   end

   // Invalid slots always hold zero fields, so shifting them around keeps the empty head at 0
   always_comb begin
      valid_next = entry_valid;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         priority_next[i] = entry_priority[i];
         data_next[i]     = entry_data[i];
      end
      case (op)
         OP_PUSH: begin
            for (int i = 1; i < NUM_ELEMENTS; i++) begin
               if (!le[i] && !ins_at[i]) begin
                  valid_next[i]    = entry_valid[i-1];
                  priority_next[i] = entry_priority[i-1];
                  data_next[i]     = entry_data[i-1];
               end
            end
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
               if (ins_at[i]) begin
                  valid_next[i]    = 1'b1;
                  priority_next[i] = i__enqueue_priority;
                  data_next[i]     = i__enqueue_data;
               end
            end
         end
         OP_POP: begin
            for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
               valid_next[i]    = entry_valid[i+1];
               priority_next[i] = entry_priority[i+1];
               data_next[i]     = entry_data[i+1];
            end
            valid_next[NUM_ELEMENTS-1]    = 1'b0;
            priority_next[NUM_ELEMENTS-1] = '0;
            data_next[NUM_ELEMENTS-1]     = '0;
         end
         OP_PUSH_POP: begin
            for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
               if (le[i+1]) begin
                  valid_next[i]    = entry_valid[i+1];
                  priority_next[i] = entry_priority[i+1];
                  data_next[i]     = entry_data[i+1];
               end
            end
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
               if (ins_pp[i]) begin
                  valid_next[i]    = 1'b1;
                  priority_next[i] = i__enqueue_priority;
                  data_next[i]     = i__enqueue_data;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         entry_valid   <= '0;
         for (int i = 0; i < NUM_ELEMENTS; i++) begin
            entry_priority[i] <= '0;
            entry_data[i]     <= '0;
         end
         o__occupancy  <= '0;
         o__pifo_full  <= 1'b0;
         o__pifo_empty <= 1'b1;
         o__overflow   <= 1'b0;
         o__underflow  <= 1'b0;
      end else begin
         entry_valid   <= valid_next;
         for (int i = 0; i < NUM_ELEMENTS; i++) begin
            entry_priority[i] <= priority_next[i];
            entry_data[i]     <= data_next[i];
         end
         o__occupancy  <= occ_next;
         o__pifo_full  <= (occ_next == OCC_WIDTH'(NUM_ELEMENTS));
         o__pifo_empty <= (occ_next == '0);
         o__overflow   <= overflow_next;
         o__underflow  <= underflow_next;
      end
   end

`ifdef PIFO_DROP_TAIL_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         o__drop_valid <= 1'b0;
         o__drop_data  <= '0;
      end else begin
         o__drop_valid <= evict;
         o__drop_data  <= evict ? entry_data[NUM_ELEMENTS-1] : '0;
      end
   end
`else
   assign o__drop_valid = 1'b0;
   assign o__drop_data  = '0;
`endif

   assign o__dequeue_priority = entry_priority[0];
   assign o__dequeue_data     = entry_data[0];

endmodule

// File: tb/tb_pifo_sorted.sv
// tb_pifo_sorted: scoreboard bench for pifo_sorted (N=4); a sorted-list model predicts every cycle.
// Expectations follow PIFO_DROP_TAIL_EN when the macro is defined for the build.
module tb_pifo_sorted;

   localparam int N  = 4;
   localparam int PW = 8;
   localparam int DW = 16;
   localparam int OW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          enqueue;
   logic [PW-1:0] enqueue_priority;
   logic [DW-1:0] enqueue_data;
   logic          dequeue;
   logic [PW-1:0] dequeue_priority;
   logic [DW-1:0] dequeue_data;
   logic          pifo_full;
   logic          pifo_empty;
   logic [OW-1:0] occupancy;
   logic          overflow;
   logic          underflow;
   logic          drop_valid;
   logic [DW-1:0] drop_data;

   typedef struct packed {
      logic [PW-1:0] prio;
      logic [DW-1:0] data;
   } item_t;

   typedef struct packed {
      logic [PW-1:0] prio;
      logic [DW-1:0] data;
      logic [OW-1:0] occ;
      logic          full;
      logic          empty;
      logic          ovf;
      logic          unf;
      logic          dv;
      logic [DW-1:0] dd;
   } exp_t;

   item_t model_q[$];
   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;

   pifo_sorted #(.NUM_ELEMENTS(N), .PRIORITY_WIDTH(PW), .DATA_WIDTH(DW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .i__enqueue          (enqueue),
      .i__enqueue_priority (enqueue_priority),
      .i__enqueue_data     (enqueue_data),
      .i__dequeue          (dequeue),
      .o__dequeue_priority (dequeue_priority),
      .o__dequeue_data     (dequeue_data),
      .o__pifo_full        (pifo_full),
      .o__pifo_empty       (pifo_empty),
      .o__occupancy        (occupancy),
      .o__overflow         (overflow),
      .o__underflow        (underflow),
      .o__drop_valid       (drop_valid),
      .o__drop_data        (drop_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic pushExpected(input logic ovf, input logic unf, input logic dv, input logic [DW-1:0] dd);
      exp_t e;
      e.prio  = (model_q.size() > 0) ? model_q[0].prio : '0;
      e.data  = (model_q.size() > 0) ? model_q[0].data : '0;
      e.occ   = OW'(model_q.size());
      e.full  = (model_q.size() == N);
      e.empty = (model_q.size() == 0);
      e.ovf   = ovf;
      e.unf   = unf;
      e.dv    = dv;
      e.dd    = dd;
      exp_q.push_back(e);
   endtask

   task automatic modelInsert(input logic [PW-1:0] p, input logic [DW-1:0] d);
      item_t it;
      int idx = 0;
      it.prio = p;
      it.data = d;
      while (idx < model_q.size() && model_q[idx].prio <= p) idx++;
      model_q.insert(idx, it);
   endtask

   task automatic modelStep(input logic enq, input logic [PW-1:0] p, input logic [DW-1:0] d, input logic deq);
      logic          was_full  = (model_q.size() == N);
      logic          was_empty = (model_q.size() == 0);
      logic          popping   = deq && !was_empty;
      logic          ovf = 1'b0;
      logic          dv  = 1'b0;
      logic [DW-1:0] dd  = '0;
      if (popping) void'(model_q.pop_front());
      if (enq) begin
         if (!was_full || popping) begin
            modelInsert(p, d);
         end else begin
`ifdef PIFO_DROP_TAIL_EN
            if (p < model_q[N-1].prio) begin
               dv = 1'b1;
               dd = model_q[N-1].data;
               void'(model_q.pop_back());
               modelInsert(p, d);
            end else begin
               ovf = 1'b1;
            end
`else
            ovf = 1'b1;
`endif
         end
      end
      pushExpected(ovf, deq && was_empty, dv, dd);
   endtask

   task automatic checkCycle(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_scoreboard"}, 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      checkOutput({tag, "_prio"},  32'(dequeue_priority), 32'(e.prio));
      checkOutput({tag, "_data"},  32'(dequeue_data),     32'(e.data));
      checkOutput({tag, "_occ"},   32'(occupancy),        32'(e.occ));
      checkOutput({tag, "_full"},  32'(pifo_full),        32'(e.full));
      checkOutput({tag, "_empty"}, 32'(pifo_empty),       32'(e.empty));
      checkOutput({tag, "_ovf"},   32'(overflow),         32'(e.ovf));
      checkOutput({tag, "_unf"},   32'(underflow),        32'(e.unf));
      checkOutput({tag, "_dv"},    32'(drop_valid),       32'(e.dv));
      checkOutput({tag, "_dd"},    32'(drop_data),        32'(e.dd));
   endtask

   task automatic applyStimulus(input string tag, input logic enq, input logic [PW-1:0] p,
                                input logic [DW-1:0] d, input logic deq);
      enqueue          = enq;
      enqueue_priority = p;
      enqueue_data     = d;
      dequeue          = deq;
      modelStep(enq, p, d, deq);
      @(posedge clk);
      #1;
      enqueue = 1'b0;
      dequeue = 1'b0;
      checkCycle(tag);
   endtask

   // Requests held active during reset must be ignored
   task automatic applyReset(input string tag);
      reset            = 1'b0;
      enqueue          = 1'b1;
      enqueue_priority = 8'd1;
      enqueue_data     = 16'hDEAD;
      dequeue          = 1'b1;
      model_q.delete();
      pushExpected(1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      enqueue = 1'b0;
      dequeue = 1'b0;
      checkCycle(tag);
   endtask

   initial begin
      reset = 1'b0;
      enqueue = 1'b0;
      enqueue_priority = '0;
      enqueue_data = '0;
      dequeue = 1'b0;
      applyReset("reset");
      applyStimulus("idle", 1'b0, 8'd0, 16'h0, 1'b0);

      // Stable ordering with tied ranks
      applyStimulus("push5", 1'b1, 8'd5, 16'h000A, 1'b0);
      applyStimulus("push2", 1'b1, 8'd2, 16'h000B, 1'b0);
      applyStimulus("push9", 1'b1, 8'd9, 16'h000C, 1'b0);
      applyStimulus("push2b", 1'b1, 8'd2, 16'h000D, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus("pop", 1'b0, 8'd0, 16'h0, 1'b1);
      applyStimulus("pop_empty", 1'b0, 8'd0, 16'h0, 1'b1);
      applyStimulus("after_unf", 1'b0, 8'd0, 16'h0, 1'b0);

      // Full queue: plain push, then push+pop
      for (int i = 1; i <= 4; i++) applyStimulus("fill", 1'b1, 8'(i), 16'(i * 16'h11), 1'b0);
      applyStimulus("full_push0", 1'b1, 8'd0, 16'h00EE, 1'b0);
      applyStimulus("full_idle", 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus("full_push9", 1'b1, 8'd9, 16'h0099, 1'b0);
      applyStimulus("full_pushpop3", 1'b1, 8'd3, 16'h0333, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 8'd0, 16'h0, 1'b1);

      // Empty queue push+pop
      applyStimulus("empty_pushpop7", 1'b1, 8'd7, 16'h0777, 1'b1);
      applyStimulus("empty_pushpop_idle", 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus("pop7", 1'b0, 8'd0, 16'h0, 1'b1);

      // Reset with contents
      applyStimulus("pre_rst_a", 1'b1, 8'd4, 16'h0A0A, 1'b0);
      applyStimulus("pre_rst_b", 1'b1, 8'd1, 16'h0B0B, 1'b0);
      applyStimulus("pre_rst_c", 1'b1, 8'd6, 16'h0C0C, 1'b0);
      applyReset("mid_reset");

      // Random traffic with a narrow rank range to exercise ties
      for (int i = 0; i < 300; i++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)),
                       16'($urandom), ($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
